cpu_onchip_mem_arbiter: RTL and testbench
=========================================

# cpu_onchip_mem_arbiter

Two-master arbiter that shares the single-port 16000×32 on-chip program/data memory between the CPU data master (port 0) and the image-loader DMA master (port 1). It presents one Avalon-MM slave per master, grants at most one access per clock with round-robin fairness, and forwards read data with a fixed latency of one cycle. It also filters out-of-range addresses so they never reach the RAM.

## Interface
Parameters:
- `ADDR_W`, 14, word-address width of both slaves and the memory port.
- `DATA_W`, 32, data width; byteenable width is `DATA_W/8`.
- `DEPTH`, 16000, number of implemented words; addresses ≥ `DEPTH` are out of range.
- `OOR_DATA`, 32'h0000_0000, read data returned for out-of-range reads.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `freeze`  in  1  when high, no new grants are made; an in-flight read still completes.
- `sN_address`  in  `ADDR_W`  word address (N = 0, 1).
- `sN_byteenable`  in  4  byte lanes for writes.
- `sN_read` / `sN_write`  in  1  request strobes; held until accepted.
- `sN_writedata`  in  32  write data.
- `sN_waitrequest`  out  1  high means the request is not accepted this cycle.
- `sN_readdata`  out  32  read data, valid only while `sN_readdatavalid` is high.
- `sN_readdatavalid`  out  1  one-cycle pulse carrying read data.
- `sN_oor_err`  out  1  sticky flag, set by any out-of-range access on port N.
- `mem_address`  out  `ADDR_W`  address to the RAM.
- `mem_byteenable`  out  4  byte enables to the RAM.
- `mem_chipselect`, `mem_write`  out  1  RAM strobes.
- `mem_writedata`  out  32  write data to the RAM.
- `mem_clken`  out  1  RAM clock enable.
- `mem_readdata`  in  32  RAM output; the address is registered inside the RAM, so data is valid one cycle after the address.

## Operation
- Request on port N: `req_N = sN_read | sN_write`. If both `sN_read` and `sN_write` are high, the access is treated as a write.
- Arbitration uses a round-robin flag `last`; at reset `last` = 1, so port 0 wins the first conflict.
  - Only one port requests: that port is granted.
  - Both ports request: the port ≠ `last` is granted.
  - `last` updates to the granted port on each grant.
- No grant is made while `freeze` or `reset` is high.
- `sN_waitrequest = ~grant_N`. The waitrequest path is combinational from the requests, `last` and `freeze`. During reset both waitrequests are high.
- In-range grant: the mux drives `mem_*` from the granted port, with `mem_chipselect` = 1 and `mem_write` = the granted port's write.
- Out-of-range grant (address ≥ `DEPTH`):
  - `mem_chipselect` = 0 and the write is dropped.
  - The access is still accepted.
  - `sN_oor_err` is set; it clears only on reset.
  - A read returns `OOR_DATA` with normal latency.
- Read-return tracking uses registered `rd_pend`, `rd_port` and `rd_oor`. The return port's `readdata` is `rd_oor ? OOR_DATA : mem_readdata`; the other port's `readdata` is 0.
- `mem_clken = ~freeze | rd_pend`, so data is not lost across a freeze.
- Idle cycles drive `mem_chipselect` = 0, `mem_write` = 0, and port 0's address and data.

## Timing
- Accept at the rising edge ending cycle T, when request is high and `waitrequest` is low.
- Read data appears in cycle T+1 with `sN_readdatavalid` = 1 for exactly one cycle.
- Throughput is one access per cycle in total. Back-to-back reads from alternating ports return in grant order with no bubbles.
- A write is committed to the RAM at the accept edge; there is no response for writes.
- Reset values: `rd_pend` = 0, both `readdatavalid` = 0, both `oor_err` = 0, `last` = 1. All `mem_*` strobes are 0 during reset.
- Reset asserted while a read is in flight: `rd_pend` clears and no `readdatavalid` is issued.
- A new request on the same port may be accepted in the same cycle that its previous read returns.

## Structure
- Package `cpu_onchip_mem_pkg` holds `ADDR_W`, `DATA_W`, `DEPTH` and the port-index constants `PORT_CPU` = 0 and `PORT_DMA` = 1.
- Sub-module `rr_arb2`: a two-way round-robin arbiter with inputs `req[1:0]` and `hold`, output a one-hot `grant`, and an internal `last` flag. The top level contains the mux, out-of-range check, and read-return registers.

## Test plan
- Port 0 alone writes 0xA5A5_1234 to address 0x0010 with byteenable 4'hF, then reads it back → readdata 0xA5A5_1234 with `s0_readdatavalid` at accept+1 and `s0_waitrequest` low both cycles.
- Both ports read continuously for 8 cycles → grants alternate 0,1,0,1…, each port gets exactly 4 accepts, and the return port matches grant order each cycle.
- Port 1 writes byteenable 4'b0010 with data 0x0000_AB00 over 0xFFFF_FFFF at address 5 → a later read returns 0xFFFF_ABFF.
- Port 0 reads address 16000 → `mem_chipselect` = 0, readdata = `OOR_DATA` at T+1, `s0_oor_err` = 1 and still 1 after 10 idle cycles; `s1_oor_err` = 0.
- `freeze` raised in the cycle after a read is accepted → that read still returns valid data; both waitrequests stay high until freeze drops, then grants resume.
- Reset pulsed one cycle after a read is accepted → no `readdatavalid`, all outputs at their reset values, and port 0 wins the first conflict after reset.

Source files
------------

// File: rtl/cpu_onchip_mem_pkg.sv
// Shared constants for the on-chip program/data memory arbiter.
// Holds the default bus geometry and the master port indices.
package cpu_onchip_mem_pkg;

    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 16000;

    localparam int unsigned PORT_CPU = 0;
    localparam int unsigned PORT_DMA = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request per master
//   hold       : suppresses all grants while high
//   grant[1:0] : one-hot grant (all zero when nothing is granted)
// The internal last flag remembers the most recently granted master; on a
// conflict the other master wins. It resets to the DMA port so the CPU wins
// the first conflict.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       hold,
    output logic [1:0] grant
);
    import cpu_onchip_mem_pkg::*;

    logic last_q;
    logic last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        grant = 2'b00;
        if (!hold) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant != 2'b00) begin
            last_d = grant[PORT_DMA];
        end
    end

endmodule

// File: rtl/cpu_onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between the CPU data master (s0) and the
// image-loader DMA master (s1).
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   freeze              : blocks new grants; an in-flight read still returns
//   sN_*                : Avalon-MM slave per master (address, byteenable,
//                         read, write, writedata, waitrequest, readdata,
//                         readdatavalid) plus sticky out-of-range flag oor_err
//   mem_*               : RAM port; mem_readdata valid one cycle after address
// At most one access per clock is granted. Out-of-range accesses are accepted
// but never reach the RAM; reads of them return OOR_DATA with normal latency.
module cpu_onchip_mem_arbiter #(
    parameter int unsigned        ADDR_W   = cpu_onchip_mem_pkg::ADDR_W,
    parameter int unsigned        DATA_W   = cpu_onchip_mem_pkg::DATA_W,
    parameter int unsigned        DEPTH    = cpu_onchip_mem_pkg::DEPTH,
    parameter logic [DATA_W-1:0]  OOR_DATA = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  freeze,

    input  logic [ADDR_W-1:0]     s0_address,
    input  logic [DATA_W/8-1:0]   s0_byteenable,
    input  logic                  s0_read,
    input  logic                  s0_write,
    input  logic [DATA_W-1:0]     s0_writedata,
    output logic                  s0_waitrequest,
    output logic [DATA_W-1:0]     s0_readdata,
    output logic                  s0_readdatavalid,
    output logic                  s0_oor_err,

    input  logic [ADDR_W-1:0]     s1_address,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic                  s1_waitrequest,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_oor_err,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);
    import cpu_onchip_mem_pkg::*;

    logic [1:0]          req;
    logic [1:0]          grant;
    logic                any_grant;
    logic                sel;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W/8-1:0] sel_byteenable;
    logic [DATA_W-1:0]   sel_writedata;
    logic                sel_write;
    logic                sel_oor;
    logic                acc_read;

    logic                rd_pend_q;
    logic                rd_port_q;
    logic                rd_oor_q;
    logic [1:0]          oor_err_q;
    logic [1:0]          oor_err_d;
    logic [1:0]          ret_valid;
    logic [DATA_W-1:0]   ret_data;

    assign req = {s1_read | s1_write, s0_read | s0_write};

    // Reset also holds the arbiter so both waitrequests are high during reset.
    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .hold  (freeze | reset),
        .grant (grant)
    );

    assign any_grant      = |grant;
    assign sel            = grant[PORT_DMA];
    assign s0_waitrequest = ~grant[PORT_CPU];
    assign s1_waitrequest = ~grant[PORT_DMA];

    // Idle cycles fall through to port 0's address and data.
    always_comb begin
        if (sel) begin
            sel_address    = s1_address;
            sel_byteenable = s1_byteenable;
            sel_writedata  = s1_writedata;
            sel_write      = s1_write;
        end else begin
            sel_address    = s0_address;
            sel_byteenable = s0_byteenable;
            sel_writedata  = s0_writedata;
            sel_write      = s0_write;
        end
    end

    assign sel_oor  = 32'(sel_address) >= DEPTH;
    // Read+write together counts as a write, so no read response then.
    assign acc_read = any_grant & ~sel_write;

    assign mem_address    = sel_address;
    assign mem_byteenable = sel_byteenable;
    assign mem_writedata  = sel_writedata;
    assign mem_chipselect = any_grant & ~sel_oor;
    assign mem_write      = any_grant & ~sel_oor & sel_write;
    // Keep the RAM clocked while a read is returning, even under freeze.
    assign mem_clken      = ~freeze | rd_pend_q;

    assign oor_err_d = oor_err_q | (grant & {2{sel_oor}});

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
            rd_oor_q  <= 1'b0;
            oor_err_q <= 2'b00;
        end else begin
            rd_pend_q <= acc_read;
            rd_port_q <= sel;
            rd_oor_q  <= sel_oor;
            oor_err_q <= oor_err_d;
        end
    end

    // A read caught by reset in its return cycle is dropped.
    assign ret_valid = {rd_port_q, ~rd_port_q} & {2{rd_pend_q & ~reset}};
    assign ret_data  = rd_oor_q ? OOR_DATA : mem_readdata;

    assign s0_readdatavalid = ret_valid[PORT_CPU];
    assign s1_readdatavalid = ret_valid[PORT_DMA];
    assign s0_readdata      = ret_valid[PORT_CPU] ? ret_data : '0;
    assign s1_readdata      = ret_valid[PORT_DMA] ? ret_data : '0;
    assign s0_oor_err       = oor_err_q[PORT_CPU];
    assign s1_oor_err       = oor_err_q[PORT_DMA];

endmodule

// File: tb/tb_cpu_onchip_mem_arbiter.sv
// Bench for cpu_onchip_mem_arbiter: a RAM harness, per-port request queues,
// a reference model of arbitration and memory contents feeding a scoreboard,
// and a monitor that checks every read return.
module tb_cpu_onchip_mem_arbiter;

    localparam int unsigned DEPTH = 16000;
    localparam logic [31:0] OOR   = 32'hDEAD_0BAD;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic freeze = 1'b0;

    logic        b_rd [2];
    logic        b_wr [2];
    logic [13:0] b_addr [2];
    logic [3:0]  b_be [2];
    logic [31:0] b_wd [2];

    logic        s0_waitrequest, s1_waitrequest;
    logic [31:0] s0_readdata, s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic        s0_oor_err, s1_oor_err;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata, mem_readdata;

    logic [31:0] ram [0:16383];
    logic [31:0] shadow [0:16383];
    logic [13:0] ram_addr_q = '0;

    req_t pq [2][$];
    exp_t sb [$];
    logic [1:0] acc = 2'b00;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dut_acc [2] = '{0, 0};

    cpu_onchip_mem_arbiter #(
        .OOR_DATA (OOR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .freeze           (freeze),
        .s0_address       (b_addr[0]),
        .s0_byteenable    (b_be[0]),
        .s0_read          (b_rd[0]),
        .s0_write         (b_wr[0]),
        .s0_writedata     (b_wd[0]),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s0_oor_err       (s0_oor_err),
        .s1_address       (b_addr[1]),
        .s1_byteenable    (b_be[1]),
        .s1_read          (b_rd[1]),
        .s1_write         (b_wr[1]),
        .s1_writedata     (b_wd[1]),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .s1_oor_err       (s1_oor_err),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM harness: registered address, byte-lane writes, clock enable.
    always @(posedge clk) begin
        if (mem_clken) begin
            if (mem_chipselect && mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            ram_addr_q <= mem_address;
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic put(input int p, input logic rd, input logic wr, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.be = be; r.data = d;
        pq[p].push_back(r);
    endtask

    task automatic put_rand(input int p);
        int k;
        logic [13:0] a;
        k = $urandom_range(0, 9);
        a = ($urandom_range(0, 9) == 0) ? 14'($urandom_range(16000, 16383))
                                         : 14'($urandom_range(0, 63));
        put(p, (k >= 2 && k <= 5) || k == 9, k >= 6, a, 4'($urandom_range(0, 15)), $urandom);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((pq[0].size() > 0 || pq[1].size() > 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (pq[0].size() > 0 || pq[1].size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d/%0d pending want 0/0", pq[0].size(), pq[1].size());
            pq[0].delete();
            pq[1].delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_acc(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (acc == 2'b00 && n < 40);
        if (acc == 2'b00) begin
            total++;
            bad++;
            $display("FAIL %s: got no grant want a grant within 40 cycles", name);
        end
    endtask

    // Driver: present each queued request until accepted; idle entries last one cycle.
    initial begin
        logic pres [2];
        req_t r;
        pres = '{1'b0, 1'b0};
        for (int p = 0; p < 2; p++) begin
            b_rd[p] = 0; b_wr[p] = 0; b_addr[p] = '0; b_be[p] = '0; b_wd[p] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (pres[p] && (acc[p] || !(pq[p][0].rd || pq[p][0].wr))) begin
                    void'(pq[p].pop_front());
                end
                pres[p] = pq[p].size() > 0;
                if (pres[p]) begin
                    r = pq[p][0];
                    b_rd[p] = r.rd; b_wr[p] = r.wr; b_addr[p] = r.addr;
                    b_be[p] = r.be; b_wd[p] = r.data;
                end else begin
                    b_rd[p] = 0; b_wr[p] = 0; b_addr[p] = '0; b_be[p] = '0; b_wd[p] = '0;
                end
            end
        end
    end

    // Reference model: who should win this cycle, what the RAM port should
    // see, and what each accept does to memory contents and error flags.
    initial begin
        logic [1:0] r, g, m_oor;
        logic m_rdp, wr, oor;
        int m_last, p;
        logic [13:0] a;
        m_last = 1;
        m_oor = 2'b00;
        m_rdp = 0;
        forever begin
            @(negedge clk);
            r = {b_rd[1] | b_wr[1], b_rd[0] | b_wr[0]};
            if (reset || freeze) g = 2'b00;
            else if (r == 2'b11) g = (m_last == 1) ? 2'b01 : 2'b10;
            else g = r;
            p = g[1] ? 1 : 0;
            wr = b_wr[p];
            a = b_addr[p];
            oor = 32'(a) >= DEPTH;
            chk("s0_waitrequest", s0_waitrequest, !g[0]);
            chk("s1_waitrequest", s1_waitrequest, !g[1]);
            chk("oor_err", {s1_oor_err, s0_oor_err}, m_oor);
            chk("mem_clken", mem_clken, !freeze || m_rdp);
            chk("mem_chipselect", mem_chipselect, (g != 0) && !oor);
            chk("mem_write", mem_write, (g != 0) && !oor && wr);
            if (g != 0 && !oor) chk("mem_address", mem_address, a);
            if (g != 0 && !oor && wr)
                chk("mem_wdata", {mem_byteenable, mem_writedata}, {b_be[p], b_wd[p]});
            acc = g;
            m_rdp = 0;
            if (reset) begin
                m_last = 1;
                m_oor = 2'b00;
            end else if (g != 0) begin
                m_last = p;
                if (oor) m_oor[p] = 1'b1;
                if (wr) begin
                    if (!oor) begin
                        for (int b = 0; b < 4; b++)
                            if (b_be[p][b]) shadow[a][8*b +: 8] = b_wd[p][8*b +: 8];
                    end
                end else begin
                    sb.push_back('{p, oor ? OOR : shadow[a], cyc + 1});
                    m_rdp = 1;
                end
            end
        end
    end

    // Monitor: every cycle compare the return strobes against the scoreboard.
    initial begin
        logic [1:0] ev;
        exp_t e;
        forever begin
            @(negedge clk);
            ev = 2'b00;
            if (reset) sb.delete();
            else if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                ev = (e.port == 1) ? 2'b10 : 2'b01;
            end
            chk("readdatavalid", {s1_readdatavalid, s0_readdatavalid}, ev);
            if (ev != 0) begin
                chk("readdata", (e.port == 1) ? s1_readdata : s0_readdata, e.data);
                chk("other_readdata", (e.port == 1) ? s0_readdata : s1_readdata, 0);
            end
            if (!reset) begin
                if ((b_rd[0] || b_wr[0]) && !s0_waitrequest) dut_acc[0]++;
                if ((b_rd[1] || b_wr[1]) && !s1_waitrequest) dut_acc[1]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        for (int i = 0; i < 16384; i++) begin
            ram[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
            shadow[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Port 0 write then read back.
        put(0, 0, 1, 14'h0010, 4'hF, 32'hA5A5_1234);
        put(0, 1, 0, 14'h0010, 4'h0, 32'h0);
        drain(50);

        // Both ports read continuously: four accepts each, alternating.
        c0 = dut_acc[0];
        c1 = dut_acc[1];
        for (int i = 0; i < 4; i++) begin
            put(0, 1, 0, 14'($urandom_range(0, 63)), 4'h0, 32'h0);
            put(1, 1, 0, 14'($urandom_range(0, 63)), 4'h0, 32'h0);
        end
        drain(50);
        chk("cpu_accepts", dut_acc[0] - c0, 4);
        chk("dma_accepts", dut_acc[1] - c1, 4);

        // Port 1 partial byte write.
        put(1, 0, 1, 14'd5, 4'hF, 32'hFFFF_FFFF);
        put(1, 0, 1, 14'd5, 4'b0010, 32'h0000_AB00);
        put(1, 1, 0, 14'd5, 4'h0, 32'h0);
        drain(50);

        // Out-of-range read on port 0; flag stays set.
        put(0, 1, 0, 14'd16000, 4'h0, 32'h0);
        drain(50);
        repeat (10) @(negedge clk);
        chk("s0_oor_sticky", s0_oor_err, 1);
        chk("s1_oor_clear", s1_oor_err, 0);

        // Freeze in the cycle after a read is accepted.
        put(0, 1, 0, 14'h0010, 4'h0, 32'h0);
        put(1, 1, 0, 14'd3, 4'h0, 32'h0);
        wait_acc("freeze_grant");
        @(posedge clk);
        #1 freeze = 1'b1;
        put(0, 1, 0, 14'd7, 4'h0, 32'h0);
        repeat (4) @(negedge clk);
        chk("frozen_waitrequest", {s1_waitrequest, s0_waitrequest}, 2'b11);
        @(posedge clk);
        #1 freeze = 1'b0;
        drain(50);

        // Reset while a read is in flight.
        put(0, 1, 0, 14'h0010, 4'h0, 32'h0);
        wait_acc("reset_grant");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_oor_err", {s1_oor_err, s0_oor_err}, 2'b00);
        chk("reset_valid", {s1_readdatavalid, s0_readdatavalid}, 2'b00);
        put(0, 1, 0, 14'd1, 4'h0, 32'h0);
        put(1, 1, 0, 14'd2, 4'h0, 32'h0);
        @(negedge clk);
        chk("first_grant_after_reset", {s1_waitrequest, s0_waitrequest}, 2'b10);
        drain(50);

        // Random traffic with occasional single-cycle freezes.
        for (int i = 0; i < 300; i++) begin
            put_rand(0);
            put_rand(1);
        end
        for (int i = 0; i < 3000 && (pq[0].size() > 0 || pq[1].size() > 0); i++) begin
            @(posedge clk);
            #1 freeze = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk);
        #1 freeze = 1'b0;
        @(negedge clk);
        drain(100);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
